fpu_to_int: RTL and testbench



---
 rtl/fpu_to_int.sv | 219 +++++++++++++++++++++
 tb/tb_fpu_to_int.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_to_int.sv
// fpu_to_int: converts the FPU result word (sign, 6-bit exponent with bias 31,
// 25-bit fraction with hidden one) into a signed 32-bit integer. The integer is
// rounded to nearest, with ties away from zero. It uses a start/busy/done
// handshake and a bit-serial shifter, one bit per cycle.
module fpu_to_int (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fp_in,
  input  logic [3:0]  fp_status_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic [3:0]  status_out
);

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fp_q, fp_d;          // captured input word
  logic [3:0]  st_q, st_d;          // captured input status
  logic [31:0] mag_q, mag_d;        // working magnitude
  logic        guard_q, guard_d;    // last bit shifted out (half LSB)
  logic        sticky_q, sticky_d;  // OR of all bits below guard
  logic [4:0]  cnt_q, cnt_d;        // remaining shift steps
  logic        left_q, left_d;      // shift direction: 1 = left
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inx_q, inx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] int_q, int_d;
  logic [3:0]  status_q, status_d;

  logic [5:0]  exp_s;
  logic [24:0] frac_s;
  logic [25:0] man_s;
  logic [5:0]  rsh_s;
  logic [5:0]  lsh_s;
  logic [31:0] rnd_s;

  assign exp_s  = fp_q[30:25];
  assign frac_s = fp_q[24:0];
  assign man_s  = {1'b1, frac_s};
  assign rsh_s  = 6'd56 - exp_s;
  assign lsh_s  = exp_s - 6'd56;
  assign rnd_s  = mag_q + {31'd0, guard_q};

  // Next-state and datapath control for the conversion sequence.
  always_comb begin
    state_d  = state_q;
    fp_d     = fp_q;
    st_d     = st_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    int_d    = int_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fp_d     = fp_in;
          st_d     = fp_status_in;
          mag_d    = 32'd0;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          cnt_d    = 5'd0;
          left_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        // Special cases go straight to OUT; the rest set up the shifter.
        if ((st_q == ST_OVERFLOW) || (st_q == ST_UNDERFLOW)) begin
          mag_d   = 32'd0;
          ovf_d   = (st_q == ST_OVERFLOW);
          unf_d   = (st_q == ST_UNDERFLOW);
          state_d = S_OUT;
        end else if (exp_s == 6'd0) begin
          mag_d   = 32'd0;
          unf_d   = (frac_s != 25'd0);
          state_d = S_OUT;
        end else if (exp_s <= 6'd29) begin
          mag_d   = 32'd0;
          unf_d   = 1'b1;
          state_d = S_OUT;
        end else if ((exp_s == 6'd62) && fp_q[31] && (frac_s == 25'd0)) begin
          mag_d   = 32'h8000_0000;
          state_d = S_OUT;
        end else if (exp_s >= 6'd62) begin
          mag_d   = fp_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          ovf_d   = 1'b1;
          state_d = S_OUT;
        end else if (exp_s <= 6'd55) begin
          mag_d   = {6'd0, man_s};
          cnt_d   = rsh_s[4:0];
          left_d  = 1'b0;
          state_d = S_SHIFT;
        end else if (exp_s == 6'd56) begin
          mag_d   = {6'd0, man_s};
          state_d = S_ROUND;
        end else begin
          mag_d   = {6'd0, man_s};
          cnt_d   = lsh_s[4:0];
          left_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[30:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[31:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ROUND: begin
        mag_d   = rnd_s;
        inx_d   = guard_q | sticky_q | (st_q == ST_INEXACT);
        unf_d   = (rnd_s == 32'd0);
        state_d = S_OUT;
      end
      S_OUT: begin
        // Negating zero yields zero, so negative zero never escapes.
        int_d = fp_q[31] ? (32'd0 - mag_q) : mag_q;
        if (ovf_q) begin
          status_d = ST_OVERFLOW;
        end else if (unf_q) begin
          status_d = ST_UNDERFLOW;
        end else if (inx_q) begin
          status_d = ST_INEXACT;
        end else begin
          status_d = ST_EXACT;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fp_q     <= 32'd0;
      st_q     <= 4'd0;
      mag_q    <= 32'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      int_q    <= 32'd0;
      status_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      fp_q     <= fp_d;
      st_q     <= st_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      int_q    <= int_d;
      status_q <= status_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign int_out    = int_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_to_int.sv
// Directed testbench for fpu_to_int with hand-computed expected results.
module tb_fpu_to_int;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] fp_in;
  logic [3:0]  fp_status_in;
  logic        busy;
  logic        done;
  logic [31:0] int_out;
  logic [3:0]  status_out;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] EX  = 4'b0001;
  localparam logic [3:0] INX = 4'b0010;
  localparam logic [3:0] OVF = 4'b0100;
  localparam logic [3:0] UNF = 4'b1000;

  fpu_to_int dut (
    .clock100KHz (clk),
    .reset       (rst_n),
    .start       (start),
    .fp_in       (fp_in),
    .fp_status_in(fp_status_in),
    .busy        (busy),
    .done        (done),
    .int_out     (int_out),
    .status_out  (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one conversion; report result, latency in edges after the capture
  // edge (-1 on timeout), busy just after capture and busy when done is seen.
  task automatic run_conv(input logic [31:0] f, input logic [3:0] s,
                          output logic [31:0] r, output logic [3:0] rs,
                          output int lat, output logic busy0, output logic busy_end);
    @(negedge clk);
    fp_in = f;
    fp_status_in = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy;
    lat = -1;
    busy_end = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        busy_end = busy;
        break;
      end
    end
    r = int_out;
    rs = status_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fp_in = 32'd0;
    fp_status_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, int_out, status_out} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b int=%h st=%b, want all zero",
               busy, done, int_out, status_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, int_out, status_out} !== 38'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b int=%h st=%b, want all zero",
               busy, done, int_out, status_out);
    end
  endtask

  // Shifted conversions with rounding, ties, sticky bits and latency.
  task automatic test_rounding();
    logic [31:0] vin [9];
    logic [31:0] vexp [9];
    logic [3:0]  sexp [9];
    int          lexp [9];
    logic [31:0] r;
    logic [3:0]  rs;
    int          lat;
    logic        b0, be;
    vin = '{32'h3E000000, 32'h3F000000, 32'hC0800000, 32'h3D000000, 32'hBD000000,
            32'h70000000, 32'h7A000000, 32'h3E800000, 32'h3F800000};
    vexp = '{32'h00000001, 32'h00000002, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFF,
             32'h02000000, 32'h40000000, 32'h00000001, 32'h00000002};
    sexp = '{EX, INX, INX, INX, INX, EX, EX, INX, INX};
    lexp = '{28, 28, 27, 29, 29, 3, 8, 28, 28};
    for (int i = 0; i < 9; i++) begin
      run_conv(vin[i], EX, r, rs, lat, b0, be);
      checks++;
      if (r !== vexp[i] || rs !== sexp[i]) begin
        errors++;
        $display("FAIL round_result[%0d] in=%h: got %h/%b, want %h/%b",
                 i, vin[i], r, rs, vexp[i], sexp[i]);
      end
      checks++;
      if (lat !== lexp[i]) begin
        errors++;
        $display("FAIL round_latency[%0d]: got %0d, want %0d", i, lat, lexp[i]);
      end
      checks++;
      if (b0 !== 1'b1 || be !== 1'b0) begin
        errors++;
        $display("FAIL round_busy[%0d]: got start=%b at_done=%b, want 1/0", i, b0, be);
      end
    end
  endtask

  // Fast paths: saturation, signed extremes, zero, underflow.
  task automatic test_saturation();
    logic [31:0] vin [7];
    logic [31:0] vexp [7];
    logic [3:0]  sexp [7];
    logic [31:0] r;
    logic [3:0]  rs;
    int          lat;
    logic        b0, be;
    vin = '{32'h7E000000, 32'hFE000000, 32'hFC000000, 32'h00000000,
            32'h00000001, 32'h3A000000, 32'h7C000000};
    vexp = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000,
             32'h00000000, 32'h00000000, 32'h7FFFFFFF};
    sexp = '{OVF, OVF, EX, EX, UNF, UNF, OVF};
    for (int i = 0; i < 7; i++) begin
      run_conv(vin[i], EX, r, rs, lat, b0, be);
      checks++;
      if (r !== vexp[i] || rs !== sexp[i] || lat !== 2) begin
        errors++;
        $display("FAIL sat_result[%0d] in=%h: got %h/%b lat=%0d, want %h/%b lat=2",
                 i, vin[i], r, rs, lat, vexp[i], sexp[i]);
      end
    end
  endtask

  // Incoming FPU status is propagated or merged.
  task automatic test_status_in();
    logic [31:0] r;
    logic [3:0]  rs;
    int          lat;
    logic        b0, be;
    run_conv(32'h3F000000, OVF, r, rs, lat, b0, be);
    checks++;
    if (r !== 32'd0 || rs !== OVF || lat !== 2) begin
      errors++;
      $display("FAIL status_ovf_in: got %h/%b lat=%0d, want 0/0100 lat=2", r, rs, lat);
    end
    run_conv(32'h7E000000, UNF, r, rs, lat, b0, be);
    checks++;
    if (r !== 32'd0 || rs !== UNF || lat !== 2) begin
      errors++;
      $display("FAIL status_unf_in: got %h/%b lat=%0d, want 0/1000 lat=2", r, rs, lat);
    end
    run_conv(32'h3E000000, INX, r, rs, lat, b0, be);
    checks++;
    if (r !== 32'd1 || rs !== INX || lat !== 28) begin
      errors++;
      $display("FAIL status_inx_in: got %h/%b lat=%0d, want 1/0010 lat=28", r, rs, lat);
    end
  endtask

  // A start pulse during a conversion is ignored; results are held afterwards.
  task automatic test_busy_start();
    int          ndone;
    logic [31:0] res;
    @(negedge clk);
    fp_in = 32'h3E000000;
    fp_status_in = EX;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    fp_in = 32'h7E000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res = 32'hDEADBEEF;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        res = int_out;
      end
    end
    checks++;
    if (ndone !== 1 || res !== 32'd1) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d done(s) int=%h, want 1 done int=00000001",
               ndone, res);
    end
    checks++;
    if (int_out !== 32'd1 || status_out !== EX) begin
      errors++;
      $display("FAIL result_held: got %h/%b, want 00000001/0001", int_out, status_out);
    end
  endtask

  // Reset during SHIFT clears outputs at once and suppresses done.
  task automatic test_reset_mid();
    int          ndone;
    logic [31:0] r;
    logic [3:0]  rs;
    int          lat;
    logic        b0, be;
    @(negedge clk);
    fp_in = 32'h3F000000;
    fp_status_in = EX;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, int_out, status_out} !== 38'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b int=%h st=%b, want all zero",
               busy, done, int_out, status_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", ndone);
    end
    run_conv(32'hC0800000, EX, r, rs, lat, b0, be);
    checks++;
    if (r !== 32'hFFFFFFFD || rs !== INX || lat !== 27) begin
      errors++;
      $display("FAIL after_reset_conv: got %h/%b lat=%0d, want FFFFFFFD/0010 lat=27",
               r, rs, lat);
    end
  endtask

  // A new start in the IDLE cycle that carries done is accepted.
  task automatic test_back_to_back();
    logic [31:0] r;
    logic [3:0]  rs;
    int          lat;
    logic        b0, be;
    run_conv(32'h7A000000, EX, r, rs, lat, b0, be);
    run_conv(32'hFC000000, EX, r, rs, lat, b0, be);
    checks++;
    if (r !== 32'h80000000 || rs !== EX || lat !== 2 || b0 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got %h/%b lat=%0d busy=%b, want 80000000/0001 lat=2 busy=1",
               r, rs, lat, b0);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_status_in();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
